// File: rtl/regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// regfile_wb_queue
//
// Write-side front end for the GP register file write port. Results from the
// single-cycle ALU path and the multi-cycle MUL/DIV unit are gathered into a
// small in-order queue. The queue drains one entry per cycle onto the
// register file write port. Decode can look up queued results that have not
// been written yet, on two independent read ports.
//
// Parameters
//   DEPTH              number of queue entries (power of 2, >= 2)
//
// Ports
//   Clk_Core           core clock, all state updates on the rising edge
//   Rst_Core_N         asynchronous active-low reset
//   Mdu_Wb_Valid/Addr/Data, Mdu_Wb_Ready   MUL/DIV writeback handshake
//   Alu_Wb_Valid/Addr/Data, Alu_Wb_Ready   ALU/load writeback handshake
//   Write_Addr_Port_1/Write_Data_Port_1/Wr_En   register file write port
//                                          (queue head; zero when empty)
//   Read_Addr_Port_1/2  decode source register addresses
//   Fwd_Hit_1/2, Fwd_Data_1/2   youngest queued match per read port
//   Wb_Empty           queue holds no pending writes
// ---------------------------------------------------------------------------
module regfile_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        Clk_Core,
    input  logic        Rst_Core_N,

    input  logic        Mdu_Wb_Valid,
    input  logic [4:0]  Mdu_Wb_Addr,
    input  logic [31:0] Mdu_Wb_Data,
    output logic        Mdu_Wb_Ready,

    input  logic        Alu_Wb_Valid,
    input  logic [4:0]  Alu_Wb_Addr,
    input  logic [31:0] Alu_Wb_Data,
    output logic        Alu_Wb_Ready,

    output logic [4:0]  Write_Addr_Port_1,
    output logic [31:0] Write_Data_Port_1,
    output logic        Wr_En,

    input  logic [4:0]  Read_Addr_Port_1,
    output logic        Fwd_Hit_1,
    output logic [31:0] Fwd_Data_1,

    input  logic [4:0]  Read_Addr_Port_2,
    output logic        Fwd_Hit_2,
    output logic [31:0] Fwd_Data_2,

    output logic        Wb_Empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]       entry_addr [DEPTH];
    logic [31:0]      entry_data [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic             pop;
    logic             need_m;
    logic             need_a;
    logic             push_m;
    logic             push_a;
    logic [CW:0]      free_slots;
    logic [PW-1:0]    alu_slot;
    logic [PW-1:0]    fwd_idx;

    // The register file always accepts a write, so the head leaves on every
    // edge where the queue is non-empty.
    assign pop = (count != '0);

    // The slot vacated by this cycle's pop is usable by this cycle's pushes,
    // which is what keeps a full queue streaming at one entry per cycle.
    assign free_slots = (CW + 1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};

    // Writes to x0 are architecturally dead: they are always accepted but
    // never take a slot, so they must not stall the producer either.
    assign need_m = Mdu_Wb_Valid & (Mdu_Wb_Addr != 5'd0);
    assign need_a = Alu_Wb_Valid & (Alu_Wb_Addr != 5'd0);

    assign Mdu_Wb_Ready = (free_slots >= (CW + 1)'(1)) | (Mdu_Wb_Addr == 5'd0);
    assign Alu_Wb_Ready = (free_slots >= ((CW + 1)'(1) + {{CW{1'b0}}, need_m}))
                        | (Alu_Wb_Addr == 5'd0);

    assign push_m = need_m & Mdu_Wb_Ready;
    assign push_a = need_a & Alu_Wb_Ready;

    // MUL/DIV results are older than a same-cycle ALU result, so the MDU
    // entry takes the tail slot and the ALU entry lands right behind it.
    assign alu_slot = push_m ? (wr_ptr + PW'(1)) : wr_ptr;

    // Queue control state. Pointers wrap naturally because DEPTH is a power
    // of two; full and empty are told apart by count alone. When the queue is
    // full the tail and head coincide, so the pop clear is written first and
    // a same-slot push overrides it.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (pop) begin
                entry_valid[rd_ptr] <= 1'b0;
            end
            if (push_m) begin
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (push_a) begin
                entry_valid[alu_slot] <= 1'b1;
            end
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(push_m) + PW'(push_a);
            count  <= count - CW'(pop) + CW'(push_m) + CW'(push_a);
        end
    end

    // Entry payload storage. Contents are only ever observed through a set
    // valid bit, so the payload needs no reset.
    always_ff @(posedge Clk_Core) begin
        if (push_m) begin
            entry_addr[wr_ptr] <= Mdu_Wb_Addr;
            entry_data[wr_ptr] <= Mdu_Wb_Data;
        end
        if (push_a) begin
            entry_addr[alu_slot] <= Alu_Wb_Addr;
            entry_data[alu_slot] <= Alu_Wb_Data;
        end
    end

    // Drain port. Outputs are forced to zero when nothing is queued so the
    // register file never sees stale head contents.
    assign Wr_En             = pop;
    assign Wb_Empty          = ~pop;
    assign Write_Addr_Port_1 = pop ? entry_addr[rd_ptr] : 5'd0;
    assign Write_Data_Port_1 = pop ? entry_data[rd_ptr] : 32'd0;

    // Forwarding search. Entries are walked from head (oldest) to tail
    // (youngest), so a later match overwrites an earlier one and the most
    // recent pending write to a register wins. Results still in their
    // handshake cycle are not in the array yet and are naturally excluded.
    always_comb begin
        Fwd_Hit_1  = 1'b0;
        Fwd_Data_1 = 32'd0;
        Fwd_Hit_2  = 1'b0;
        Fwd_Data_2 = 32'd0;
        fwd_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if (entry_valid[fwd_idx] && (CW'(i) < count)) begin
                if ((Read_Addr_Port_1 != 5'd0) &&
                    (entry_addr[fwd_idx] == Read_Addr_Port_1)) begin
                    Fwd_Hit_1  = 1'b1;
                    Fwd_Data_1 = entry_data[fwd_idx];
                end
                if ((Read_Addr_Port_2 != 5'd0) &&
                    (entry_addr[fwd_idx] == Read_Addr_Port_2)) begin
                    Fwd_Hit_2  = 1'b1;
                    Fwd_Data_2 = entry_data[fwd_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_queue
//
// Self-checking bench for regfile_wb_queue. A queue-based reference model
// tracks the pending writes in order; every cycle the expected drain port,
// readies and forwarding results are derived from that model and compared
// with the design outputs.
// ---------------------------------------------------------------------------
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    logic        Clk_Core   = 1'b0;
    logic        Rst_Core_N = 1'b0;
    logic        Mdu_Wb_Valid = 1'b0;
    logic [4:0]  Mdu_Wb_Addr  = 5'd0;
    logic [31:0] Mdu_Wb_Data  = 32'd0;
    logic        Mdu_Wb_Ready;
    logic        Alu_Wb_Valid = 1'b0;
    logic [4:0]  Alu_Wb_Addr  = 5'd0;
    logic [31:0] Alu_Wb_Data  = 32'd0;
    logic        Alu_Wb_Ready;
    logic [4:0]  Write_Addr_Port_1;
    logic [31:0] Write_Data_Port_1;
    logic        Wr_En;
    logic [4:0]  Read_Addr_Port_1 = 5'd0;
    logic        Fwd_Hit_1;
    logic [31:0] Fwd_Data_1;
    logic [4:0]  Read_Addr_Port_2 = 5'd0;
    logic        Fwd_Hit_2;
    logic [31:0] Fwd_Data_2;
    logic        Wb_Empty;

    int checks = 0;
    int errors = 0;

    // Reference model: pending writes in program order, head at index 0.
    logic [4:0]  mq_addr [$];
    logic [31:0] mq_data [$];

    logic [106:0] exp_vec;
    logic         exp_mrdy;
    logic         exp_ardy;

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .Clk_Core          (Clk_Core),
        .Rst_Core_N        (Rst_Core_N),
        .Mdu_Wb_Valid      (Mdu_Wb_Valid),
        .Mdu_Wb_Addr       (Mdu_Wb_Addr),
        .Mdu_Wb_Data       (Mdu_Wb_Data),
        .Mdu_Wb_Ready      (Mdu_Wb_Ready),
        .Alu_Wb_Valid      (Alu_Wb_Valid),
        .Alu_Wb_Addr       (Alu_Wb_Addr),
        .Alu_Wb_Data       (Alu_Wb_Data),
        .Alu_Wb_Ready      (Alu_Wb_Ready),
        .Write_Addr_Port_1 (Write_Addr_Port_1),
        .Write_Data_Port_1 (Write_Data_Port_1),
        .Wr_En             (Wr_En),
        .Read_Addr_Port_1  (Read_Addr_Port_1),
        .Fwd_Hit_1         (Fwd_Hit_1),
        .Fwd_Data_1        (Fwd_Data_1),
        .Read_Addr_Port_2  (Read_Addr_Port_2),
        .Fwd_Hit_2         (Fwd_Hit_2),
        .Fwd_Data_2        (Fwd_Data_2),
        .Wb_Empty          (Wb_Empty)
    );

    always #5 Clk_Core = ~Clk_Core;

    function automatic logic [106:0] observed();
        return {Wr_En, Write_Addr_Port_1, Write_Data_Port_1, Wb_Empty,
                Mdu_Wb_Ready, Alu_Wb_Ready, Fwd_Hit_1, Fwd_Data_1,
                Fwd_Hit_2, Fwd_Data_2};
    endfunction

    task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic [4:0] r1, input logic [4:0] r2);
        Mdu_Wb_Valid     = mv;
        Mdu_Wb_Addr      = ma;
        Mdu_Wb_Data      = md;
        Alu_Wb_Valid     = av;
        Alu_Wb_Addr      = aa;
        Alu_Wb_Data      = ad;
        Read_Addr_Port_1 = r1;
        Read_Addr_Port_2 = r2;
    endtask

    // Expected outputs for the current inputs and the pending-write list.
    task automatic model_expect();
        int          sz;
        int          free_s;
        int          need_m;
        logic        h1, h2;
        logic [31:0] d1, d2;
        sz     = mq_addr.size();
        free_s = DEPTH - sz + ((sz != 0) ? 1 : 0);
        need_m = (Mdu_Wb_Valid && Mdu_Wb_Addr != 0) ? 1 : 0;
        exp_mrdy = (free_s >= 1) || (Mdu_Wb_Addr == 0);
        exp_ardy = (free_s >= 1 + need_m) || (Alu_Wb_Addr == 0);
        h1 = 1'b0; d1 = 32'd0;
        h2 = 1'b0; d2 = 32'd0;
        for (int i = sz - 1; i >= 0; i--) begin
            if (!h1 && Read_Addr_Port_1 != 0 && mq_addr[i] == Read_Addr_Port_1) begin
                h1 = 1'b1;
                d1 = mq_data[i];
            end
            if (!h2 && Read_Addr_Port_2 != 0 && mq_addr[i] == Read_Addr_Port_2) begin
                h2 = 1'b1;
                d2 = mq_data[i];
            end
        end
        exp_vec = {(sz != 0), (sz != 0) ? mq_addr[0] : 5'd0,
                   (sz != 0) ? mq_data[0] : 32'd0, (sz == 0),
                   exp_mrdy, exp_ardy, h1, d1, h2, d2};
    endtask

    // Advance the model across one rising edge: head retires, then the
    // accepted results join the tail, MUL/DIV first.
    task automatic tick();
        @(posedge Clk_Core);
        if (mq_addr.size() != 0) begin
            void'(mq_addr.pop_front());
            void'(mq_data.pop_front());
        end
        if (Mdu_Wb_Valid && exp_mrdy && Mdu_Wb_Addr != 0) begin
            mq_addr.push_back(Mdu_Wb_Addr);
            mq_data.push_back(Mdu_Wb_Data);
        end
        if (Alu_Wb_Valid && exp_ardy && Alu_Wb_Addr != 0) begin
            mq_addr.push_back(Alu_Wb_Addr);
            mq_data.push_back(Alu_Wb_Data);
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd9, 32'h1234_5678, 1'b1, 5'd10, 32'h9ABC_DEF0, 5'd9, 5'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk_Core);
            #1;
            checks++;
            if ({Wr_En, Wb_Empty, Fwd_Hit_1, Fwd_Hit_2} !== 4'b0100) begin
                errors++;
                $display("[TB] FAIL reset_hold cycle %0d: got WrEn/Empty/Hit1/Hit2=%b required 0100",
                         i, {Wr_En, Wb_Empty, Fwd_Hit_1, Fwd_Hit_2});
            end
        end
        @(negedge Clk_Core);
        Rst_Core_N = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd10);
        #1;
        model_expect();
        checks++;
        if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h required %h", observed(), exp_vec);
        end
        tick();
    endtask

    task automatic test_single_alu();
        @(negedge Clk_Core);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        #1;
        model_expect();
        checks++;
        if ({Alu_Wb_Ready, Wr_En} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL single_handshake: got Ready/WrEn=%b required 10", {Alu_Wb_Ready, Wr_En});
        end
        tick();
        @(negedge Clk_Core);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        model_expect();
        checks++;
        if ({Wr_En, Write_Addr_Port_1, Write_Data_Port_1} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL single_write: got en=%b addr=%0d data=%h required en=1 addr=5 data=deadbeef",
                     Wr_En, Write_Addr_Port_1, Write_Data_Port_1);
        end
        tick();
        @(negedge Clk_Core);
        #1;
        model_expect();
        checks++;
        if ({Wr_En, Wb_Empty} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL single_empty: got WrEn/Empty=%b required 01", {Wr_En, Wb_Empty});
        end
        tick();
    endtask

    task automatic test_dual_stream();
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk_Core);
            drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd3, 5'd4);
            #1;
            model_expect();
            checks++;
            if (observed() !== exp_vec) begin
                errors++;
                $display("[TB] FAIL dual_stream cycle %0d: got %h required %h", i, observed(), exp_vec);
            end
            // Queue reaches four entries after three double pushes; from then
            // on the ALU must yield to the MUL/DIV result.
            checks++;
            if (Alu_Wb_Ready !== ((i < 3) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("[TB] FAIL dual_alu_ready cycle %0d: got %b required %b",
                         i, Alu_Wb_Ready, (i < 3) ? 1'b1 : 1'b0);
            end
            tick();
        end
    endtask

    task automatic test_addr_zero();
        @(negedge Clk_Core);
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #1;
        model_expect();
        checks++;
        if (Alu_Wb_Ready !== 1'b1 || Wb_Empty !== 1'b0) begin
            errors++;
            $display("[TB] FAIL addr0_ready: got ready=%b empty=%b required ready=1 empty=0",
                     Alu_Wb_Ready, Wb_Empty);
        end
        checks++;
        if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL addr0_vector: got %h required %h", observed(), exp_vec);
        end
        tick();
        for (int i = 0; i < 10 && mq_addr.size() != 0; i++) begin
            @(negedge Clk_Core);
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
            #1;
            model_expect();
            checks++;
            if (observed() !== exp_vec || (Wr_En && Write_Addr_Port_1 == 5'd0)) begin
                errors++;
                $display("[TB] FAIL addr0_drain cycle %0d: got %h required %h", i, observed(), exp_vec);
            end
            tick();
        end
        @(negedge Clk_Core);
        #1;
        checks++;
        if ({Wr_En, Wb_Empty} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL addr0_drained: got WrEn/Empty=%b required 01", {Wr_En, Wb_Empty});
        end
    endtask

    task automatic test_forward();
        @(negedge Clk_Core);
        drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 5'd7, 5'd0);
        #1;
        model_expect();
        checks++;
        if (Fwd_Hit_1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fwd_inflight: got hit=%b required 0", Fwd_Hit_1);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk_Core);
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
            #1;
            model_expect();
            checks++;
            if ({Fwd_Hit_1, Fwd_Data_1, Fwd_Hit_2, Fwd_Data_2} !==
                ((i < 2) ? {1'b1, 32'hB, 1'b0, 32'd0} : {1'b0, 32'd0, 1'b0, 32'd0})) begin
                errors++;
                $display("[TB] FAIL fwd_youngest cycle %0d: got hit1=%b d1=%h hit2=%b d2=%h required hit1=%b d1=%h",
                         i, Fwd_Hit_1, Fwd_Data_1, Fwd_Hit_2, Fwd_Data_2,
                         (i < 2) ? 1'b1 : 1'b0, (i < 2) ? 32'hB : 32'd0);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk_Core);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            model_expect();
            checks++;
            if (observed() !== exp_vec) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %h required %h", i, observed(), exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        // Drain leftovers, then build up exactly three pending entries.
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk_Core);
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
            #1;
            model_expect();
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk_Core);
            drive(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd2, 32'h200 + i, 5'd1, 5'd2);
            #1;
            model_expect();
            tick();
        end
        @(negedge Clk_Core);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
        #1;
        model_expect();
        checks++;
        if (observed() !== exp_vec || mq_addr.size() != 3) begin
            errors++;
            $display("[TB] FAIL async_pre: got %h required %h", observed(), exp_vec);
        end
        #1;
        Rst_Core_N = 1'b0;
        mq_addr.delete();
        mq_data.delete();
        #1;
        checks++;
        if ({Wr_En, Write_Addr_Port_1, Write_Data_Port_1, Wb_Empty, Fwd_Hit_1, Fwd_Hit_2} !==
            {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_immediate: got en=%b addr=%0d data=%h empty=%b hit=%b%b required 0 0 0 1 00",
                     Wr_En, Write_Addr_Port_1, Write_Data_Port_1, Wb_Empty, Fwd_Hit_1, Fwd_Hit_2);
        end
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, 5'd6, 5'd8);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk_Core);
            #1;
            checks++;
            if ({Wr_En, Wb_Empty} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL async_hold cycle %0d: got WrEn/Empty=%b required 01", i, {Wr_En, Wb_Empty});
            end
        end
        @(negedge Clk_Core);
        Rst_Core_N = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin
                @(negedge Clk_Core);
            end
            #1;
            model_expect();
            checks++;
            if (observed() !== exp_vec || Wr_En !== 1'b0) begin
                errors++;
                $display("[TB] FAIL async_after cycle %0d: got %h required %h", i, observed(), exp_vec);
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start regfile_wb_queue DEPTH=%0d", DEPTH);
        test_reset();
        test_single_alu();
        test_dual_stream();
        test_addr_zero();
        test_forward();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
